microcode_sequencer: RTL and testbench
======================================

// Module: microcode_sequencer
// PURPOSE
// - Next-address generator feeding the microcode ROM's micro_pc input; consumes the branch fields of the microword the ROM returns.
// - The ROM registers micro_pc internally, so this block drives micro_pc combinationally from its state and the current microword.
// - Result: one microinstruction per clock. Supports sequential step, jump, conditional branch, call/return (hardware stack),
//   decoder dispatch, wait-on-condition, exception vectoring and bus stall.
// PARAMETERS
// - RESET_ADDR   9'd0    microaddress fetched after reset; also the fallback target on stack underflow
// - EXC_ADDR     9'd1    microaddress forced on exc_req
// - STACK_DEPTH  4       return-stack entries (2..8); stack_count width is 4 bits
// PORTS
// - clock        in   1  single clock; all state on rising edge
// - reset_n      in   1  asynchronous, active-low reset
// - branch_op    in   3  microword field: 0 NEXT, 1 JUMP, 2 BR_T, 3 BR_F, 4 CALL, 5 RET, 6 DISPATCH, 7 WAIT
// - branch_tgt   in   9  microword field: branch/call target
// - cond_sel     in   3  microword field: index into cond_flags
// - cond_flags   in   8  condition inputs (CCR bits, ALU/bus status), sampled in the same cycle as branch_op
// - dispatch_addr in  9  entry address from instruction decoder; used by DISPATCH
// - exc_req      in   1  one-cycle exception request
// - stall        in   1  bus wait; freezes sequencing
// - micro_pc     out  9  next microaddress to ROM (combinational)
// - cur_pc       out  9  address of the microword currently on the ROM output (registered)
// - micro_valid  out  1  ROM output holds a valid microword this cycle
// - stack_count  out  4  current return-stack occupancy
// - stack_error  out  1  sticky overflow/underflow flag
// BEHAVIOUR
// - Reset (reset_n=0, async): cur_pc=RESET_ADDR, micro_valid=0, stack_count=0, stack_error=0, stack contents don't-care;
//   micro_pc=RESET_ADDR.
// - First rising edge after reset release: ROM fetches RESET_ADDR and micro_valid becomes 1.
//   While micro_valid=0, all inputs except reset_n are ignored and micro_pc=RESET_ADDR.
// - Each edge with micro_valid=1: cur_pc <= micro_pc, and the stack updates as below.
// - Priority, highest first: stall > exc_req > branch_op.
// - stall=1: micro_pc=cur_pc, so the ROM re-reads and presents the same word. No stack change; exc_req is ignored
//   (the source holds it).
// - exc_req=1: micro_pc=EXC_ADDR; stack_count cleared to 0; stack_error unchanged.
// - inc = cur_pc+1, 9-bit, so 9'h1FF wraps to 9'h000. cond = cond_flags[cond_sel].
// - NEXT: inc.
// - JUMP: branch_tgt.
// - BR_T: cond ? branch_tgt : inc.
// - BR_F: cond ? inc : branch_tgt.
// - CALL: push inc, go to branch_tgt.
//   If stack_count==STACK_DEPTH: no push, stack_error<=1, still go to branch_tgt.
// - RET: pop the top entry and go to it.
//   If stack_count==0: go to RESET_ADDR, stack_error<=1, count stays 0.
// - DISPATCH: dispatch_addr.
// - WAIT: cond ? inc : cur_pc, i.e. spins on the same word until cond is 1.
// - Stack is LIFO. Push writes entry[stack_count] and increments; pop reads entry[stack_count-1] and decrements.
//   Only one push or pop per cycle.
// - stack_error is cleared only by reset.
// - Reset asserted mid-call chain: stack is discarded; sequencing resumes at RESET_ADDR per the reset rule above.
// TESTING
// - Reset release: cur_pc=0 -> micro_pc=0 while micro_valid=0; after 1st edge micro_valid=1; NEXT x3 -> cur_pc 1,2,3.
// - BR_T with cond_sel=5, cond_flags=8'h20 at cur_pc=9'h010, tgt=9'h080 -> next cur_pc=9'h080;
//   cond_flags=8'h00 -> next cur_pc=9'h011.
// - CALL tgt 9'h100 from 9'h020 then RET -> cur_pc 9'h100 then 9'h021.
//   5 nested CALLs (depth 4) -> stack_error=1, stack_count=4.
// - RET with stack_count=0 -> cur_pc=RESET_ADDR, stack_error=1. NEXT at 9'h1FF -> cur_pc=9'h000.
// - stall=1 for 3 cycles during a CALL word -> cur_pc frozen, stack_count unchanged; on release, exactly one push.
// - exc_req coincident with CALL and stall=0 -> cur_pc=EXC_ADDR, stack_count=0; WAIT with cond=0 holds cur_pc until cond=1.

Source files
------------

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - microcode next-address sequencer with return stack
module microcode_sequencer #(
    parameter logic [8:0] RESET_ADDR  = 9'd0,
    parameter logic [8:0] EXC_ADDR    = 9'd1,
    parameter int         STACK_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] branch_op,
    input  logic [8:0] branch_tgt,
    input  logic [2:0] cond_sel,
    input  logic [7:0] cond_flags,
    input  logic [8:0] dispatch_addr,
    input  logic       exc_req,
    input  logic       stall,
    output logic [8:0] micro_pc,
    output logic [8:0] cur_pc,
    output logic       micro_valid,
    output logic [3:0] stack_count,
    output logic       stack_error
);

    localparam logic [2:0] OP_NEXT     = 3'd0;
    localparam logic [2:0] OP_JUMP     = 3'd1;
    localparam logic [2:0] OP_BR_T     = 3'd2;
    localparam logic [2:0] OP_BR_F     = 3'd3;
    localparam logic [2:0] OP_CALL     = 3'd4;
    localparam logic [2:0] OP_RET      = 3'd5;
    localparam logic [2:0] OP_DISPATCH = 3'd6;
    localparam logic [2:0] OP_WAIT     = 3'd7;

    localparam logic [3:0] DEPTH = 4'(STACK_DEPTH);

    // Storage sized for the largest supported depth; only the first STACK_DEPTH entries are used.
    logic [8:0] stack_mem [0:7];

    logic [8:0] inc;
    logic       cond;
    logic [2:0] top_idx;
    logic [8:0] next_pc;
    logic       do_push;
    logic       do_pop;
    logic       set_err;
    logic       clr_stack;

    assign inc      = cur_pc + 9'd1;
    assign cond     = cond_flags[cond_sel];
    assign top_idx  = stack_count[2:0] - 3'd1;
    assign micro_pc = next_pc;

    // Next-address selection: stall > exception > branch field; ROM holds RESET_ADDR until first fetch.
    always_comb begin
        next_pc   = inc;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        set_err   = 1'b0;
        clr_stack = 1'b0;
        if (!micro_valid) begin
            next_pc = RESET_ADDR;
        end else if (stall) begin
            next_pc = cur_pc;
        end else if (exc_req) begin
            next_pc   = EXC_ADDR;
            clr_stack = 1'b1;
        end else begin
            case (branch_op)
                OP_NEXT:     next_pc = inc;
                OP_JUMP:     next_pc = branch_tgt;
                OP_BR_T:     next_pc = cond ? branch_tgt : inc;
                OP_BR_F:     next_pc = cond ? inc : branch_tgt;
                OP_CALL: begin
                    next_pc = branch_tgt;
                    if (stack_count == DEPTH) set_err = 1'b1;
                    else                      do_push = 1'b1;
                end
                OP_RET: begin
                    if (stack_count == 4'd0) begin
                        next_pc = RESET_ADDR;
                        set_err = 1'b1;
                    end else begin
                        next_pc = stack_mem[top_idx];
                        do_pop  = 1'b1;
                    end
                end
                OP_DISPATCH: next_pc = dispatch_addr;
                OP_WAIT:     next_pc = cond ? inc : cur_pc;
                default:     next_pc = inc;
            endcase
        end
    end

    // Sequencer state: current address, valid flag, stack occupancy and sticky error.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_pc      <= RESET_ADDR;
            micro_valid <= 1'b0;
            stack_count <= 4'd0;
            stack_error <= 1'b0;
        end else begin
            cur_pc      <= next_pc;
            micro_valid <= 1'b1;
            if (clr_stack)    stack_count <= 4'd0;
            else if (do_push) stack_count <= stack_count + 4'd1;
            else if (do_pop)  stack_count <= stack_count - 4'd1;
            if (set_err) stack_error <= 1'b1;
        end
    end

    // Return-stack contents carry no reset; occupancy alone defines what is valid.
    always_ff @(posedge clock) begin
        if (do_push) stack_mem[stack_count[2:0]] <= inc;
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - directed self-checking bench for microcode_sequencer
module tb_microcode_sequencer;

    logic       clock;
    logic       reset_n;
    logic [2:0] branch_op;
    logic [8:0] branch_tgt;
    logic [2:0] cond_sel;
    logic [7:0] cond_flags;
    logic [8:0] dispatch_addr;
    logic       exc_req;
    logic       stall;
    logic [8:0] micro_pc;
    logic [8:0] cur_pc;
    logic       micro_valid;
    logic [3:0] stack_count;
    logic       stack_error;

    int tests;
    int errors;

    localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, BR_T = 3'd2, BR_F = 3'd3;
    localparam logic [2:0] CALL = 3'd4, RET = 3'd5, DISP = 3'd6, WAITOP = 3'd7;

    microcode_sequencer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .branch_op     (branch_op),
        .branch_tgt    (branch_tgt),
        .cond_sel      (cond_sel),
        .cond_flags    (cond_flags),
        .dispatch_addr (dispatch_addr),
        .exc_req       (exc_req),
        .stall         (stall),
        .micro_pc      (micro_pc),
        .cur_pc        (cur_pc),
        .micro_valid   (micro_valid),
        .stack_count   (stack_count),
        .stack_error   (stack_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic op(input logic [2:0] o, input logic [8:0] t);
        branch_op  = o;
        branch_tgt = t;
        step();
    endtask

    task automatic chk_pc(input string name, input logic [8:0] exp);
        tests++;
        if (cur_pc !== exp) begin
            errors++;
            $display("FAIL %s: cur_pc=%h expected %h", name, cur_pc, exp);
        end
    endtask

    task automatic chk_cnt(input string name, input logic [3:0] exp);
        tests++;
        if (stack_count !== exp) begin
            errors++;
            $display("FAIL %s: stack_count=%0d expected %0d", name, stack_count, exp);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; branch_op = JUMP; branch_tgt = 9'h055; stall = 1'b1; exc_req = 1'b1;
        cond_sel = 3'd0; cond_flags = 8'h00; dispatch_addr = 9'h000;
        step(); step();
        chk_pc("reset_cur_pc", 9'h000);
        tests++; if (micro_pc !== 9'h000) begin errors++; $display("FAIL reset_micro_pc: %h expected 000", micro_pc); end
        tests++; if (micro_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: %b expected 0", micro_valid); end
        chk_cnt("reset_count", 4'd0);
        tests++; if (stack_error !== 1'b0) begin errors++; $display("FAIL reset_err: %b expected 0", stack_error); end
        reset_n = 1'b1;
        #1;
        tests++; if (micro_pc !== 9'h000) begin errors++; $display("FAIL prefetch_micro_pc: %h expected 000", micro_pc); end
        step();
        tests++; if (micro_valid !== 1'b1) begin errors++; $display("FAIL first_valid: %b expected 1", micro_valid); end
        chk_pc("first_fetch", 9'h000);
        stall = 1'b0; exc_req = 1'b0;
    endtask

    task automatic test_next();
        op(NEXT, 9'h000); chk_pc("next1", 9'h001);
        op(NEXT, 9'h000); chk_pc("next2", 9'h002);
        op(NEXT, 9'h000); chk_pc("next3", 9'h003);
    endtask

    task automatic test_branch();
        op(JUMP, 9'h010); chk_pc("jump", 9'h010);
        cond_sel = 3'd5; cond_flags = 8'h20;
        op(BR_T, 9'h080); chk_pc("brt_taken", 9'h080);
        op(JUMP, 9'h010);
        cond_flags = 8'h00;
        op(BR_T, 9'h080); chk_pc("brt_not_taken", 9'h011);
        cond_flags = 8'h20;
        op(BR_F, 9'h0C0); chk_pc("brf_cond1", 9'h012);
        cond_flags = 8'hDF;
        op(BR_F, 9'h0C0); chk_pc("brf_cond0", 9'h0C0);
        dispatch_addr = 9'h1A5;
        op(DISP, 9'h000); chk_pc("dispatch", 9'h1A5);
    endtask

    task automatic test_call_ret();
        op(JUMP, 9'h020);
        op(CALL, 9'h100); chk_pc("call", 9'h100); chk_cnt("call_cnt", 4'd1);
        op(RET, 9'h000);  chk_pc("ret", 9'h021);  chk_cnt("ret_cnt", 4'd0);
    endtask

    task automatic test_wrap();
        op(JUMP, 9'h1FF);
        op(NEXT, 9'h000); chk_pc("wrap", 9'h000);
    endtask

    task automatic test_stall();
        op(JUMP, 9'h030);
        branch_op = CALL; branch_tgt = 9'h140; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exc_req = (i == 1);
            tests++; if (micro_pc !== 9'h030) begin errors++; $display("FAIL stall_micro_pc%0d: %h expected 030", i, micro_pc); end
            step();
            chk_pc("stall_hold", 9'h030); chk_cnt("stall_cnt", 4'd0);
        end
        stall = 1'b0; exc_req = 1'b0;
        step(); chk_pc("stall_release", 9'h140); chk_cnt("stall_push", 4'd1);
        op(NEXT, 9'h000); chk_cnt("stall_one_push", 4'd1);
        op(RET, 9'h000);  chk_pc("stall_ret", 9'h031);
    endtask

    task automatic test_exception();
        op(CALL, 9'h150); chk_cnt("exc_pre", 4'd1);
        exc_req = 1'b1;
        op(CALL, 9'h160); chk_pc("exc_pc", 9'h001); chk_cnt("exc_cnt", 4'd0);
        exc_req = 1'b0;
    endtask

    task automatic test_wait();
        cond_sel = 3'd2; cond_flags = 8'h00; branch_op = WAITOP;
        for (int i = 0; i < 3; i++) begin
            step(); chk_pc("wait_hold", 9'h001);
        end
        cond_flags = 8'h04;
        step(); chk_pc("wait_release", 9'h002);
    endtask

    task automatic test_underflow();
        tests++; if (stack_error !== 1'b0) begin errors++; $display("FAIL err_before_uf: %b expected 0", stack_error); end
        op(RET, 9'h000); chk_pc("uf_pc", 9'h000); chk_cnt("uf_cnt", 4'd0);
        tests++; if (stack_error !== 1'b1) begin errors++; $display("FAIL uf_err: %b expected 1", stack_error); end
    endtask

    task automatic test_reset_mid_call();
        op(CALL, 9'h100); op(CALL, 9'h101); chk_cnt("mid_cnt", 4'd2);
        #2 reset_n = 1'b0;
        #1;
        chk_pc("mid_reset_pc", 9'h000); chk_cnt("mid_reset_cnt", 4'd0);
        tests++; if (micro_valid !== 1'b0 || stack_error !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: valid=%b err=%b expected 0 0", micro_valid, stack_error); end
        step();
        reset_n = 1'b1;
        step();
        tests++; if (micro_valid !== 1'b1) begin errors++; $display("FAIL mid_restart_valid: %b expected 1", micro_valid); end
        chk_pc("mid_restart_pc", 9'h000);
    endtask

    task automatic test_overflow();
        op(CALL, 9'h100); chk_cnt("ov1", 4'd1);
        op(CALL, 9'h101); chk_cnt("ov2", 4'd2);
        op(CALL, 9'h102); chk_cnt("ov3", 4'd3);
        op(CALL, 9'h103); chk_cnt("ov4", 4'd4);
        tests++; if (stack_error !== 1'b0) begin errors++; $display("FAIL ov_err_early: %b expected 0", stack_error); end
        op(CALL, 9'h104); chk_cnt("ov5", 4'd4); chk_pc("ov5_pc", 9'h104);
        tests++; if (stack_error !== 1'b1) begin errors++; $display("FAIL ov_err: %b expected 1", stack_error); end
        op(RET, 9'h000); chk_pc("lifo1", 9'h103);
        op(RET, 9'h000); chk_pc("lifo2", 9'h102);
        op(RET, 9'h000); chk_pc("lifo3", 9'h101);
        op(RET, 9'h000); chk_pc("lifo4", 9'h001); chk_cnt("lifo_cnt", 4'd0);
    endtask

    initial begin
        tests = 0;
        errors = 0;
        test_reset();
        test_next();
        test_branch();
        test_call_ret();
        test_wrap();
        test_stall();
        test_exception();
        test_wait();
        test_underflow();
        test_reset_mid_call();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
